// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: assembles framed din bits into a WIDTH-bit word
// and hands it downstream with a valid/ready handshake, flagging dropped bits.
//
// state | meaning
// IDLE  | no frame in progress, no word pending
// SHIFT | collecting bits of a frame (busy=1)
// FULL  | completed word held on Q awaiting q_ready (q_valid=1)
module serial_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic             r_busy;
  logic             r_overrun;

  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_start_sreg;
  logic [CNT_W-1:0] w_start_cnt;
  logic             w_last;

  // A bit arriving with start belongs to the new frame and uses the new dir.
  always_comb begin
    w_shift      = '0;
    w_start_sreg = '0;
    w_start_cnt  = '0;
    w_last       = 1'b0;
    if (r_dir) w_shift = {r_sreg[WIDTH-2:0], din};
    else       w_shift = {din, r_sreg[WIDTH-1:1]};
    if (din_valid) begin
      w_start_cnt = CNT_W'(1);
      if (dir) w_start_sreg = {{(WIDTH-1){1'b0}}, din};
      else     w_start_sreg = {din, {(WIDTH-1){1'b0}}};
    end
    w_last = (r_cnt == CNT_W'(WIDTH-1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_SHIFT;
            r_busy    <= 1'b1;
            r_dir     <= dir;
            r_overrun <= 1'b0;
            r_cnt     <= w_start_cnt;
            r_sreg    <= w_start_sreg;
          end
        end

        S_SHIFT: begin
          if (start) begin
            r_dir     <= dir;
            r_overrun <= 1'b0;
            r_cnt     <= w_start_cnt;
            r_sreg    <= w_start_sreg;
          end else if (din_valid) begin
            r_sreg <= w_shift;
            if (w_last) begin
              r_q       <= w_shift;
              r_q_valid <= 1'b1;
              r_busy    <= 1'b0;
              r_cnt     <= '0;
              r_state   <= S_FULL;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        S_FULL: begin
          // Only accept+start re-opens a frame; any other valid bit is lost.
          if (q_ready && start) begin
            r_q_valid <= 1'b0;
            r_state   <= S_SHIFT;
            r_busy    <= 1'b1;
            r_dir     <= dir;
            r_overrun <= 1'b0;
            r_cnt     <= w_start_cnt;
            r_sreg    <= w_start_sreg;
          end else begin
            if (q_ready) begin
              r_q_valid <= 1'b0;
              r_state   <= S_IDLE;
            end
            if (din_valid) r_overrun <= 1'b1;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_q_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Q       = r_q;
  assign q_valid = r_q_valid;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Receive side of the shift-register serial path: collects a framed serial bit stream (din/dir) into a WIDTH-bit parallel word.
- Presents the word on Q with a valid/ready handshake to the downstream datapath (adder4/comp4 operands).
- Bit order per frame is selectable: MSB-first or LSB-first.
- Backpressure is handled by holding the word and flagging any dropped bits.

Parameters:
- WIDTH, 4, word width in bits (>=2).
- CNT_W, 3, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- start  input  1  frame start; begins a new frame, aborting any partial one.
- dir  input  1  bit order, sampled only on start: 1 = MSB-first, 0 = LSB-first.
- din  input  1  serial data bit.
- din_valid  input  1  din carries a valid bit this cycle.
- Q  output  WIDTH  assembled word.
- q_valid  output  1  Q holds an unconsumed word.
- q_ready  input  1  consumer accepts Q when q_valid=1.
- busy  output  1  frame in progress (state SHIFT).
- overrun  output  1  sticky: a valid bit was dropped in FULL.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; shift register, bit count and latched dir cleared.
  - Q=0, q_valid=0, busy=0, overrun=0.
  - Applies immediately, including mid-frame or while FULL; any partial or unconsumed word is lost.
- States are IDLE, SHIFT and FULL. All transitions occur on the rising clk edge.
- IDLE (busy=0, q_valid=0):
  - din_valid alone is ignored.
  - start=1: go to SHIFT, count=0, latch dir, clear overrun.
  - If din_valid=1 in the same cycle as start, that bit is captured as bit 1 of the frame (count=1).
- SHIFT (busy=1): each cycle with din_valid=1 captures din and increments count.
  - dir=1: sreg <= {sreg[WIDTH-2:0], din}. The first bit ends at the MSB.
  - dir=0: sreg <= {din, sreg[WIDTH-1:1]}. The first bit ends at the LSB.
  - Cycles with din_valid=0 hold state (gaps allowed, no timeout).
  - dir changes after start are ignored until the next start.
  - start=1 in SHIFT: abort, restart the frame (count=0, new dir latched). A same-cycle din_valid bit becomes bit 1 of the new frame.
  - When the WIDTH-th bit is captured, on that same edge: Q <= completed word, q_valid <= 1, state -> FULL. Latency is 0 cycles after the last bit edge (registered output).
- FULL (q_valid=1, busy=0):
  - Q is held stable.
  - q_ready=1: q_valid <= 0 on that edge. Go to IDLE, or to SHIFT if start=1 in the same cycle (dir latched; a same-cycle din_valid bit is captured as bit 1).
  - din_valid=1 without a concurrent accept+start: the bit is dropped and overrun <= 1.
  - start=1 without q_ready: ignored. The word is not discarded and overrun is unaffected.
- overrun: sticky; cleared only by reset or by an accepted start (IDLE, SHIFT, or FULL with q_ready).
- Q changes only on frame completion or reset; it keeps its last word after q_valid falls.
- Counter compares count == WIDTH-1 at capture. No wrap: count never exceeds WIDTH-1 in SHIFT.
- No combinational path from inputs to outputs.

Test Plan (WIDTH=4):
1. Reset mid-frame:
   - Stimulus: start, dir=1, bits 1,1; then rst=0 for 1 cycle; then release.
   - Response: Q=0, q_valid=0, busy=0, overrun=0 immediately (async). After release, 2 valid bits leave q_valid=0.
2. MSB-first:
   - Stimulus: start+dir=1 with din_valid bits 0,1,1,0 on consecutive edges (first bit with start); q_ready=1.
   - Response: after the 4th edge, Q=4'b0110 and q_valid=1 for exactly one cycle; then IDLE.
3. LSB-first with gaps:
   - Stimulus: start+dir=0, bits 0,1,0,1 with 2 idle cycles between each; dir toggled mid-frame.
   - Response: Q=4'b1010, busy=1 throughout the frame, q_valid only after the 4th bit.
4. Backpressure/overrun:
   - Stimulus: complete 0110 (dir=1) with q_ready=0, then send 2 more valid bits, then q_ready=1.
   - Response: Q stays 4'b0110, overrun=1, q_valid falls on the accept edge. A subsequent start clears overrun.
5. Abort/restart:
   - Stimulus: start, dir=1, bits 1,1; then start again with bits 1,0,1,0.
   - Response: Q=4'b1010; no q_valid from the aborted frame.
6. Back-to-back:
   - Stimulus: in FULL (Q=0110) assert q_ready+start+din_valid(din=1, dir=0), then bits 1,0,0.
   - Response: no lost cycle; next Q=4'b0011 with q_valid=1; overrun stays 0.
